// File: rtl/falafel_pkg.sv
// Shared types and constants for the falafel allocator and its memory-side bridge.
package falafel_pkg;

    // Native word width of the allocator datapath.
    localparam int DATA_W = 64;

    // Number of byte-offset bits inside one word.
    localparam int MEM_OFF_W = $clog2(DATA_W / 8);

    // Value returned in place of data for a read that could not reach memory.
    localparam logic [DATA_W-1:0] NULL_PTR = '0;

    // One slot of the SRAM read-latency delay line.
    typedef struct packed {
        logic valid;
        logic bad;
    } mem_pipe_ent_t;

endpackage

// File: rtl/falafel_fifo.sv
// Synchronous FIFO with show-ahead read port: rdata_o always presents the head entry.
module falafel_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Pointer advance with wrap, so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + 1'b1;
    endfunction

    // Storage array: data only, deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Read/write pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop_i) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/falafel_mem_delay_line.sv
// Shift register that tracks reads through the fixed SRAM read latency.
module falafel_mem_delay_line
    import falafel_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  mem_pipe_ent_t ent_i,
    output mem_pipe_ent_t ent_o
);

    mem_pipe_ent_t stage_q [STAGES];

    // Stage 0 captures the accept-cycle entry; later stages shift one per clock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= ent_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    // Last stage lines up with the cycle the SRAM presents read data.
    assign ent_o = stage_q[STAGES-1];

endmodule

// File: rtl/falafel_mem_bridge.sv
// Bridge from falafel's valid/ready word requests to a fixed-latency single-port SRAM.
// Reads return in order through a credit-protected show-ahead buffer; writes are posted.
module falafel_mem_bridge #(
    parameter int DATA_W     = falafel_pkg::DATA_W,
    parameter int MEM_WORDS  = 1024,
    parameter int RD_LATENCY = 2,
    parameter int RESP_DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         mem_req_val_i,
    output logic                         mem_req_rdy_o,
    input  logic                         mem_req_is_write_i,
    input  logic [DATA_W-1:0]            mem_req_addr_i,
    input  logic [DATA_W-1:0]            mem_req_data_i,
    output logic                         mem_resp_val_o,
    input  logic                         mem_resp_rdy_i,
    output logic [DATA_W-1:0]            mem_resp_data_o,
    output logic                         sram_req_o,
    output logic                         sram_we_o,
    output logic [$clog2(MEM_WORDS)-1:0] sram_addr_o,
    output logic [DATA_W-1:0]            sram_wdata_o,
    input  logic [DATA_W-1:0]            sram_rdata_i,
    output logic                         err_o
);

    import falafel_pkg::*;

    localparam int OFF_W  = $clog2(DATA_W / 8);
    localparam int IDX_W  = $clog2(MEM_WORDS);
    localparam int CRED_W = $clog2(RESP_DEPTH + 1);

    logic [CRED_W-1:0] credits_q;
    logic              err_q;
    logic              accept;
    logic              rd_accept;
    logic              resp_hs;
    logic              req_bad;
    logic [DATA_W-1:0] word_idx;
    mem_pipe_ent_t     pipe_in;
    mem_pipe_ent_t     pipe_out;
    logic              fifo_push;
    logic [DATA_W-1:0] fifo_wdata;
    logic [DATA_W-1:0] fifo_rdata;
    logic              fifo_empty;
    logic              fifo_full;

    // A request is unusable if it is not word aligned or lands past the end of the SRAM.
    function automatic logic addr_is_bad(input logic [DATA_W-1:0] addr);
        logic [DATA_W-1:0] idx;
        idx = addr >> OFF_W;
        return (addr[OFF_W-1:0] != '0) || (idx >= DATA_W'(MEM_WORDS));
    endfunction

    assign word_idx  = mem_req_addr_i >> OFF_W;
    assign req_bad   = addr_is_bad(mem_req_addr_i);

    // Ready depends only on credits, so writes are throttled along with reads.
    assign mem_req_rdy_o = (credits_q != '0);
    assign accept        = mem_req_val_i & mem_req_rdy_o;
    assign rd_accept     = accept & ~mem_req_is_write_i;
    assign resp_hs       = mem_resp_val_o & mem_resp_rdy_i;

    // SRAM strobe is combinational from the accepted request; bad accesses never reach memory.
    always_comb begin
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        if (accept && !req_bad) begin
            sram_req_o   = 1'b1;
            sram_we_o    = mem_req_is_write_i;
            sram_addr_o  = word_idx[IDX_W-1:0];
            sram_wdata_o = mem_req_data_i;
        end
    end

    // One credit per buffer slot: taken by a read accept, returned by a response handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            credits_q <= CRED_W'(RESP_DEPTH);
        end else begin
            case ({rd_accept, resp_hs})
                2'b10:   credits_q <= credits_q - 1'b1;
                2'b01:   credits_q <= credits_q + 1'b1;
                default: credits_q <= credits_q;
            endcase
        end
    end

    // Sticky error flag for any accepted bad access.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (accept && req_bad) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;

    // ---- accept stage -> SRAM latency stages ----
    // Bad reads still occupy a slot so their NULL_PTR reply keeps request order.
    assign pipe_in.valid = rd_accept;
    assign pipe_in.bad   = req_bad;

    falafel_mem_delay_line #(
        .STAGES (RD_LATENCY)
    ) u_delay_line (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .ent_i  (pipe_in),
        .ent_o  (pipe_out)
    );

    // ---- SRAM data return -> response buffer ----
    assign fifo_push  = pipe_out.valid;
    assign fifo_wdata = pipe_out.bad ? DATA_W'(NULL_PTR) : sram_rdata_i;

    falafel_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (resp_hs),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // Head data is masked while empty so the port reads zero out of reset.
    assign mem_resp_val_o  = ~fifo_empty;
    assign mem_resp_data_o = fifo_empty ? '0 : fifo_rdata;

    // Credits must make a push into a full buffer impossible.
    a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(fifo_push && fifo_full && !resp_hs))
        else $error("response buffer overflow");

    // Credits never exceed the buffer size.
    a_credit_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
        credits_q <= CRED_W'(RESP_DEPTH))
        else $error("credit counter out of range");

    // A stalled response holds its data until it is taken.
    a_resp_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (mem_resp_val_o && !mem_resp_rdy_i) |=> (mem_resp_val_o && $stable(mem_resp_data_o)))
        else $error("response changed while stalled");

endmodule

// File: tb/tb_falafel_mem_bridge.sv
// Randomized bench for falafel_mem_bridge against a transaction-level reference model.
module tb_falafel_mem_bridge;

    localparam int P_DATA_W     = 64;
    localparam int P_MEM_WORDS  = 1024;
    localparam int P_RD_LATENCY = 2;
    localparam int P_RESP_DEPTH = 4;

    logic        clk_i;
    logic        rst_ni;
    logic        mem_req_val_i;
    logic        mem_req_rdy_o;
    logic        mem_req_is_write_i;
    logic [63:0] mem_req_addr_i;
    logic [63:0] mem_req_data_i;
    logic        mem_resp_val_o;
    logic        mem_resp_rdy_i;
    logic [63:0] mem_resp_data_o;
    logic        sram_req_o;
    logic        sram_we_o;
    logic [9:0]  sram_addr_o;
    logic [63:0] sram_wdata_o;
    logic [63:0] sram_rdata_i;
    logic        err_o;

    falafel_mem_bridge #(
        .DATA_W     (P_DATA_W),
        .MEM_WORDS  (P_MEM_WORDS),
        .RD_LATENCY (P_RD_LATENCY),
        .RESP_DEPTH (P_RESP_DEPTH)
    ) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .mem_req_val_i      (mem_req_val_i),
        .mem_req_rdy_o      (mem_req_rdy_o),
        .mem_req_is_write_i (mem_req_is_write_i),
        .mem_req_addr_i     (mem_req_addr_i),
        .mem_req_data_i     (mem_req_data_i),
        .mem_resp_val_o     (mem_resp_val_o),
        .mem_resp_rdy_i     (mem_resp_rdy_i),
        .mem_resp_data_o    (mem_resp_data_o),
        .sram_req_o         (sram_req_o),
        .sram_we_o          (sram_we_o),
        .sram_addr_o        (sram_addr_o),
        .sram_wdata_o       (sram_wdata_o),
        .sram_rdata_i       (sram_rdata_i),
        .err_o              (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [63:0] data;
        int          rdy_cyc;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          outstanding = 0;
    logic        err_exp = 1'b0;
    exp_t        expq[$];
    logic [63:0] sram_mem [P_MEM_WORDS];
    logic [63:0] ref_mem  [P_MEM_WORDS];
    logic [63:0] rdata_at [int];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus, model update and comparison.
    task automatic step(input logic v, input logic w, input logic [63:0] a,
                        input logic [63:0] d, input logic rr);
        logic        exp_rdy;
        logic        acc;
        logic        bad;
        logic        exp_req;
        logic        exp_val;
        logic [63:0] idx;
        exp_t        e;
        @(negedge clk_i);
        mem_req_val_i      = v;
        mem_req_is_write_i = w;
        mem_req_addr_i     = a;
        mem_req_data_i     = d;
        mem_resp_rdy_i     = rr;
        sram_rdata_i = rdata_at.exists(cyc) ? rdata_at[cyc] : {$urandom, $urandom};
        #1;
        idx     = a >> 3;
        bad     = (a[2:0] != 3'd0) || (idx >= 64'(P_MEM_WORDS));
        exp_rdy = (outstanding < P_RESP_DEPTH);
        acc     = v && exp_rdy;
        exp_req = acc && !bad;

        chk("err", err_o, err_exp);
        chk("req_rdy", mem_req_rdy_o, exp_rdy);
        chk("sram_req", sram_req_o, exp_req);
        if (exp_req) begin
            chk("sram_we", sram_we_o, w);
            chk("sram_addr", 64'(sram_addr_o), idx);
            if (w) chk("sram_wdata", sram_wdata_o, d);
        end

        exp_val = (expq.size() != 0) && (expq[0].rdy_cyc <= cyc);
        chk("resp_val", mem_resp_val_o, exp_val);
        if (exp_val) begin
            chk("resp_data", mem_resp_data_o, expq[0].data);
            if (rr) begin
                void'(expq.pop_front());
                outstanding--;
            end
        end

        if (acc && bad) err_exp = 1'b1;
        if (acc && !w) begin
            e.data    = bad ? falafel_pkg::NULL_PTR : ref_mem[idx[9:0]];
            e.rdy_cyc = cyc + P_RD_LATENCY + 1;
            expq.push_back(e);
            outstanding++;
        end
        if (acc && w && !bad) ref_mem[idx[9:0]] = d;

        // SRAM behaviour: writes land immediately, reads appear RD_LATENCY cycles later.
        if (sram_req_o) begin
            if (sram_we_o) sram_mem[sram_addr_o] = sram_wdata_o;
            else           rdata_at[cyc + P_RD_LATENCY] = sram_mem[sram_addr_o];
        end
        cyc++;
    endtask

    task automatic idle(input logic rr);
        step(1'b0, 1'b0, 64'h0, 64'h0, rr);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        mem_req_val_i  = 1'b0;
        mem_resp_rdy_i = 1'b0;
        rst_ni         = 1'b0;
        #1;
        chk("rst_req_rdy", mem_req_rdy_o, 1'b1);
        chk("rst_resp_val", mem_resp_val_o, 1'b0);
        chk("rst_resp_data", mem_resp_data_o, 64'h0);
        chk("rst_sram_req", sram_req_o, 1'b0);
        chk("rst_sram_we", sram_we_o, 1'b0);
        chk("rst_sram_addr", 64'(sram_addr_o), 64'h0);
        chk("rst_sram_wdata", sram_wdata_o, 64'h0);
        chk("rst_err", err_o, 1'b0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        expq.delete();
        rdata_at.delete();
        outstanding = 0;
        err_exp     = 1'b0;
    endtask

    function automatic logic [63:0] rand_addr();
        int unsigned r;
        logic [63:0] a;
        r = $urandom_range(0, 15);
        if (r == 0)      a = (64'($urandom_range(0, 1023)) << 3) | 64'($urandom_range(1, 7));
        else if (r == 1) a = 64'($urandom_range(1024, 1100)) << 3;
        else             a = 64'($urandom_range(0, 31)) << 3;
        return a;
    endfunction

    initial begin
        rst_ni             = 1'b0;
        mem_req_val_i      = 1'b0;
        mem_req_is_write_i = 1'b0;
        mem_req_addr_i     = '0;
        mem_req_data_i     = '0;
        mem_resp_rdy_i     = 1'b0;
        sram_rdata_i       = '0;
        for (int i = 0; i < P_MEM_WORDS; i++) begin
            sram_mem[i] = {$urandom, $urandom};
            ref_mem[i]  = sram_mem[i];
        end
        do_reset();

        // Posted write then read-back through index 8.
        step(1'b1, 1'b1, 64'h40, 64'hDEAD_BEEF, 1'b1);
        idle(1'b1);
        step(1'b1, 1'b0, 64'h40, 64'h0, 1'b1);
        repeat (5) idle(1'b1);

        // Back-to-back reads at full throughput.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 64'(i * 8), 64'h0, 1'b1);
        repeat (5) idle(1'b1);

        // Backpressure: only RESP_DEPTH reads get in.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 64'(i * 8 + 64), 64'h0, 1'b0);
        step(1'b1, 1'b0, 64'h80, 64'h0, 1'b1);
        step(1'b1, 1'b0, 64'h80, 64'h0, 1'b0);

        // Writes are throttled by credits but do not consume them.
        step(1'b1, 1'b1, 64'h100, 64'h1234_5678_9ABC_DEF0, 1'b0);
        idle(1'b1);
        step(1'b1, 1'b1, 64'h100, 64'h0BAD_F00D_CAFE_0001, 1'b0);
        idle(1'b0);
        repeat (8) idle(1'b1);

        // Out-of-range and misaligned reads return NULL_PTR in order.
        step(1'b1, 1'b0, 64'h2000, 64'h0, 1'b1);
        step(1'b1, 1'b0, 64'h4, 64'h0, 1'b1);
        repeat (5) idle(1'b1);
        step(1'b1, 1'b0, 64'h100, 64'h0, 1'b1);
        repeat (5) idle(1'b1);

        // Reset with reads in flight.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, rand_addr(), 64'h0, 1'b0);
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 64'(i * 8), 64'h0, 1'b0);
        repeat (8) idle(1'b1);

        // Randomized mix.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, rand_addr(),
                 {$urandom, $urandom}, $urandom_range(0, 3) != 0);
        end
        repeat (12) idle(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/falafel_mem_bridge.md
# falafel_mem_bridge

Memory-side bridge that sits directly downstream of the falafel allocator's memory request/response ports. It converts falafel's valid/ready word requests into accesses on a single-port, fixed-read-latency SRAM. Read data returns in request order through a credit-protected response buffer, so falafel's response backpressure never stalls the SRAM pipeline. Writes are posted and produce no response.

## Interface
- DATA_W, falafel_pkg::DATA_W: word width; addresses are byte addresses, word-aligned.
- MEM_WORDS, 1024: SRAM depth in words.
- RD_LATENCY, 2: SRAM read latency in cycles, ≥1.
- RESP_DEPTH, 4: response buffer entries and maximum reads outstanding, ≥2.
- clk_i  in  1  clock.
- rst_ni  in  1  reset. One clock; reset is asynchronous and active-low.
- mem_req_val_i  in  1  request valid, from falafel.
- mem_req_rdy_o  out  1  bridge ready.
- mem_req_is_write_i  in  1  1 = write, 0 = read.
- mem_req_addr_i  in  DATA_W  byte address.
- mem_req_data_i  in  DATA_W  write data.
- mem_resp_val_o  out  1  read data valid.
- mem_resp_rdy_i  in  1  falafel ready.
- mem_resp_data_o  out  DATA_W  read data.
- sram_req_o  out  1  SRAM access strobe.
- sram_we_o  out  1  SRAM write enable.
- sram_addr_o  out  $clog2(MEM_WORDS)  word index.
- sram_wdata_o  out  DATA_W  write data.
- sram_rdata_i  in  DATA_W  read data, valid RD_LATENCY cycles after the strobe.
- err_o  out  1  sticky error: an access was out of range or misaligned.

## Operation
- Word index = addr >> OFF_W, where OFF_W = $clog2(DATA_W/8).
- A request is bad if addr[OFF_W-1:0] != 0 or the word index is ≥ MEM_WORDS.
- Credit counter credits_q, width $clog2(RESP_DEPTH+1), resets to RESP_DEPTH.
  - mem_req_rdy_o = (credits_q != 0), independent of mem_req_is_write_i.
  - Decrements on each accepted read.
  - Increments on each response handshake (mem_resp_val_o & mem_resp_rdy_i).
  - Simultaneous read accept and response handshake: credits_q is unchanged.
- Accept = mem_req_val_i & mem_req_rdy_o.
- Good access: sram_req_o = accept, combinational in the same cycle. sram_we_o, sram_addr_o and sram_wdata_o are driven from the request.
- Bad access: sram_req_o stays 0 and err_o sets.
  - A bad write is dropped.
  - A bad read still consumes a credit and a pipeline slot, and returns NULL_PTR, which preserves ordering.
- Delay line: RD_LATENCY stages of {valid, bad}. A stage is loaded with valid=1 on a read accept and shifts every cycle.
- On stage exit, the response buffer pushes sram_rdata_i, or NULL_PTR if the entry was bad.
- The credit scheme guarantees the buffer never overflows. An overflow push is an assertion failure.
- Response buffer is show-ahead: mem_resp_val_o = !empty, and mem_resp_data_o = head entry.
- Writes do not touch credits, the delay line or the buffer.

## Timing
- Reset values: mem_req_rdy_o=1, mem_resp_val_o=0, mem_resp_data_o=0, sram_req_o=0, sram_we_o=0, sram_addr_o=0, sram_wdata_o=0, err_o=0.
- With the read accepted in cycle T:
  - sram_rdata_i is sampled in cycle T+RD_LATENCY.
  - mem_resp_val_o is high from cycle T+RD_LATENCY+1.
  - Minimum read latency is RD_LATENCY+1 cycles.
- Full throughput is one read per cycle while mem_resp_rdy_i=1 and RESP_DEPTH ≥ RD_LATENCY+1.
- A write completes in its accept cycle.
- With mem_resp_rdy_i held low, exactly RESP_DEPTH reads are accepted, then mem_req_rdy_o=0. It returns to 1 the cycle after the first response handshake.
- mem_resp_val_o, once high, stays high with stable data until the handshake.
- Reset asserted mid-operation discards the delay line and buffer, restores credits, clears err_o, and drops any SRAM read in flight.

## Structure
- falafel_pkg gains: MEM_OFF_W = $clog2(DATA_W/8), and mem_pipe_ent_t = struct {logic valid; logic bad;}.
- NULL_PTR is reused from falafel_pkg.
- Sub-module falafel_mem_delay_line holds the RD_LATENCY-stage mem_pipe_ent_t shift register, with asynchronous clear.
- The response buffer is a falafel_fifo instance, DATA_W wide with RESP_DEPTH entries, read with show-ahead semantics.

## Test plan
All scenarios use DATA_W=64, MEM_WORDS=1024, RD_LATENCY=2, RESP_DEPTH=4.
- Write addr 0x40, data 0xDEAD_BEEF; later read addr 0x40 -> sram index 8 on both accesses; the read returns 0xDEAD_BEEF with mem_resp_val_o high exactly 3 cycles after accept.
- Back-to-back reads of addr 0x0, 0x8, 0x10, 0x18 with mem_resp_rdy_i=1 -> four responses on four consecutive cycles, in order, and mem_req_rdy_o never drops.
- mem_resp_rdy_i=0 with 6 reads offered -> 4 accepted and mem_req_rdy_o=0; raise rdy for 1 cycle -> one response, then a 5th read accepted the next cycle.
- Read addr 0x2000 (index 1024), then read addr 0x4 (misaligned) -> no sram_req_o, two NULL_PTR responses in order, err_o=1 and held.
- A write accepted while credits_q=0 -> not accepted (mem_req_rdy_o=0); a write with credits_q=1 -> accepted and credits stay 1.
- Assert rst_ni low with 3 reads in flight -> after release mem_resp_val_o=0, mem_req_rdy_o=1, 4 reads accepted again, and no stale data appears.
